load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator for the data-memory port. Accepts one load/store request at a time from the core's MEM stage and converts the byte address to a word address. Issues memread/memwrite with SPRAM one-cycle read latency. Performs byte/halfword extraction with sign/zero extension on loads and read-modify-write merging on sub-word stores, because the 16-bit SPRAM halves are written with a fixed full-nibble mask.

## Interface
Parameters:
- ADDR_BITS, 14, word-address bits forwarded to memory; upper mem_addr bits zero.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; transfer when req_valid & req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data (right-justified for SB/SH).
- req_funct3  in  3  RV32I width: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
- resp_valid  out  1  one-cycle pulse, completion.
- resp_rdata  out  32  extended load data; 0 for stores/errors.
- resp_err  out  1  valid with resp_valid; misaligned or illegal funct3.
- mem_addr  out  32  word address {0, req_addr[ADDR_BITS+1:2]}.
- mem_write_data  out  32  word to write.
- mem_memwrite  out  1  write strobe.
- mem_memread  out  1  read strobe.
- mem_sign_mask  out  4  byte lanes of the access (informational).
- mem_read_data  in  32  read word, valid the cycle after mem_memread.

## Operation
- States: IDLE, LOAD, LOAD_WAIT, RMW_READ, RMW_MERGE, STORE, ERR.
- IDLE: on handshake, register addr/wdata/funct3/write. Then go to:
  - ERR if illegal (store funct3[2]=1, funct3 011/110/111, H with addr[0]=1, W with addr[1:0]≠0);
  - LOAD for any load;
  - STORE for SW;
  - RMW_READ for SB/SH.
- LOAD: mem_memread=1 → LOAD_WAIT.
- LOAD_WAIT: select lane from mem_read_data using addr[1:0]. B/H sign-extend; BU/HU zero-extend. resp_valid=1 → IDLE.
- RMW_READ: mem_memread=1 → RMW_MERGE.
- RMW_MERGE: replace the addressed byte/halfword of mem_read_data with req_wdata[7:0]/[15:0] into a merge register → STORE.
- STORE: mem_memwrite=1, mem_write_data = wdata (SW) or merge register, resp_valid=1 → IDLE.
- ERR: resp_valid=1, resp_err=1, no memory strobe → IDLE.
- mem_memread and mem_memwrite are never high together; both 0 outside LOAD/RMW_READ/STORE.
- mem_sign_mask:
  - B: 0001<<addr[1:0];
  - H: 0011<<addr[1:0];
  - W: 1111;
  - held while a strobe is high; 0 otherwise.
- Address 0x2000 word (LED register) is treated as ordinary memory.

## Timing
- Reset (rst_n=0 at edge): state IDLE. req_ready=1 after reset. All other outputs 0 (resp_valid, resp_err, resp_rdata, mem_memread, mem_memwrite, mem_sign_mask, mem_addr, mem_write_data).
- Reset mid-operation aborts with no write. A reset asserted during STORE still lets that cycle's write occur; no further strobes.
- Cycle 0 is the handshake. resp_valid timing:
  - LW/LH/LB: cycle 2;
  - SW: cycle 1;
  - SB/SH: cycle 3;
  - error: cycle 1.
- Next request is accepted in the cycle after resp_valid (req_ready rises then). No back-to-back overlap.
- resp_* are combinational from registered state/data; stable for the one response cycle.
- req_* are ignored outside IDLE.

## Structure
- Shared include lsu_defs.vh holds:
  - state encodings (3-bit localparams);
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - LED_WORD_ADDR = 32'h2000.
- Sub-module lsu_align, purely combinational: load lane extraction/extension and store lane merge. Inputs are word, addr[1:0], funct3, wdata. The FSM and registers stay in load_store_unit.

## Test plan
- Memory word 0x000 = 0x80FF7F01. LB addr 0x003 → resp_rdata 0xFFFFFF80 at cycle 2. LBU addr 0x003 → 0x00000080.
- LH addr 0x002 → 0xFFFF80FF; LHU addr 0x002 → 0x000080FF; LW addr 0x000 → 0x80FF7F01.
- SB 0xAA to addr 0x001 over 0x11223344 → RMW_READ, then write 0x1122AA44 at cycle 3. SH 0xBEEF to addr 0x002 → 0xBEEF3344.
- SW 0x000000A5 to byte addr 0x8000 → mem_addr 0x2000, mem_memwrite cycle 1, mem_sign_mask 1111.
- LW addr 0x002, SH addr 0x001, and SB with funct3 100 → resp_err=1 at cycle 1, no strobe observed.
- rst_n low during RMW_MERGE → no mem_memwrite afterwards, req_ready=1 after release, next LW completes normally.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RV32I
// width codes, LED word address and the request legality check.
package load_store_unit_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_LOAD_WAIT = 3'd2,
    S_RMW_READ  = 3'd3,
    S_RMW_MERGE = 3'd4,
    S_STORE     = 3'd5,
    S_ERR       = 3'd6
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // The LED register sits in ordinary memory space; no special handling.
  localparam logic [31:0] LED_WORD_ADDR = 32'h2000;

  function automatic logic req_illegal(input logic       write,
                                       input logic [2:0] f3,
                                       input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (f3)
      F3_B, F3_BU: bad = write && f3[2];
      F3_H, F3_HU: bad = (write && f3[2]) || lo[0];
      F3_W:        bad = |lo;
      default:     bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extraction with sign/zero extension,
// sub-word store merge into the read word, and the byte-lane mask.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data,
  output logic [3:0]  lane_mask
);

  logic [15:0] shifted;
  assign shifted = 16'(word >> {addr_lo, 3'b000});

  always_comb begin
    load_data = word;
    lane_mask = 4'b1111;
    case (funct3)
      F3_B: begin
        load_data = {{24{shifted[7]}}, shifted[7:0]};
        lane_mask = 4'b0001 << addr_lo;
      end
      F3_BU: begin
        load_data = {24'h0, shifted[7:0]};
        lane_mask = 4'b0001 << addr_lo;
      end
      F3_H: begin
        load_data = {{16{shifted[15]}}, shifted};
        lane_mask = 4'b0011 << addr_lo;
      end
      F3_HU: begin
        load_data = {16'h0, shifted};
        lane_mask = 4'b0011 << addr_lo;
      end
      default: ;
    endcase
  end

  // Memory writes whole words, so sub-word stores patch the word just read.
  always_comb begin
    merge_data = word;
    case (funct3[1:0])
      2'b00:   merge_data[{addr_lo, 3'b000} +: 8]     = wdata[7:0];
      2'b01:   merge_data[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      default: merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding data-memory initiator; loads respond in 2 cycles, SW in 1,
// SB/SH in 3 (read-modify-write), errors in 1. req_ready only while idle.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_BITS = 14
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memwrite,
  output logic        mem_memread,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data
);

  state_t               state, state_nx;
  logic [ADDR_BITS+1:0] addr_q;
  logic [31:0]          wdata_q, merge_q;
  logic [2:0]           funct3_q;
  logic [31:0]          load_data, merge_data;
  logic [3:0]           lane_mask;
  logic                 unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:ADDR_BITS+2];

  lsu_align u_align (
    .word       (mem_read_data),
    .addr_lo    (addr_q[1:0]),
    .funct3     (funct3_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data),
    .lane_mask  (lane_mask)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      merge_q  <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && req_valid) begin
        addr_q   <= req_addr[ADDR_BITS+1:0];
        wdata_q  <= req_wdata;
        funct3_q <= req_funct3;
      end
      if (state == S_RMW_MERGE) merge_q <= merge_data;
    end
  end

  assign mem_addr = {{(32-ADDR_BITS){1'b0}}, addr_q[ADDR_BITS+1:2]};

  always_comb begin
    state_nx       = state;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_err       = 1'b0;
    resp_rdata     = '0;
    mem_memread    = 1'b0;
    mem_memwrite   = 1'b0;
    mem_write_data = '0;
    mem_sign_mask  = '0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_illegal(req_write, req_funct3, req_addr[1:0])) state_nx = S_ERR;
          else if (!req_write)                                    state_nx = S_LOAD;
          else if (req_funct3 == F3_W)                            state_nx = S_STORE;
          else                                                    state_nx = S_RMW_READ;
        end
      end
      S_LOAD: begin
        mem_memread   = 1'b1;
        mem_sign_mask = lane_mask;
        state_nx      = S_LOAD_WAIT;
      end
      S_LOAD_WAIT: begin
        resp_valid = 1'b1;
        resp_rdata = load_data;
        state_nx   = S_IDLE;
      end
      S_RMW_READ: begin
        mem_memread   = 1'b1;
        mem_sign_mask = lane_mask;
        state_nx      = S_RMW_MERGE;
      end
      S_RMW_MERGE: state_nx = S_STORE;
      S_STORE: begin
        mem_memwrite   = 1'b1;
        mem_sign_mask  = lane_mask;
        mem_write_data = (funct3_q == F3_W) ? wdata_q : merge_q;
        resp_valid     = 1'b1;
        state_nx       = S_IDLE;
      end
      S_ERR: begin
        resp_valid = 1'b1;
        resp_err   = 1'b1;
        state_nx   = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a one-cycle-latency memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [2:0]  req_funct3 = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_memwrite;
  logic        mem_memread;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_read_data;

  load_store_unit #(.ADDR_BITS(14)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_funct3     (req_funct3),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_memwrite   (mem_memwrite),
    .mem_memread    (mem_memread),
    .mem_sign_mask  (mem_sign_mask),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [bit [31:0]];
  logic [31:0] rd_q = '0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          overlap = 0;

  assign mem_read_data = rd_q;

  always @(posedge clk) begin
    if (mem_memread) begin
      rd_q <= mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
      rd_cnt++;
    end
    if (mem_memwrite) begin
      mem[mem_addr] = mem_write_data;
      wr_cnt++;
    end
  end

  always @(negedge clk) if (mem_memread && mem_memwrite) overlap++;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_case(input string tag, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [2:0] f3,
                         input int exp_cyc, input logic [31:0] exp_rdata,
                         input logic exp_err, input int exp_rd, input int exp_wr,
                         input logic [3:0] exp_mask);
    int          cyc, rd0, wr0;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  mask_seen;
    cyc = -1; rdata = '0; err = 1'b0; mask_seen = '0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; req_funct3 = f3;
    @(negedge clk);
    check({tag, ".ready"}, {31'h0, req_ready}, 32'h1);
    rd0 = rd_cnt; wr0 = wr_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'hDEAD_BEEF;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_memread || mem_memwrite) mask_seen = mem_sign_mask;
      if (resp_valid) begin
        cyc = c; rdata = resp_rdata; err = resp_err;
        break;
      end
    end
    check({tag, ".cyc"},   cyc, exp_cyc);
    check({tag, ".rdata"}, rdata, exp_rdata);
    check({tag, ".err"},   {31'h0, err}, {31'h0, exp_err});
    check({tag, ".mask"},  {28'h0, mask_seen}, {28'h0, exp_mask});
    @(negedge clk);
    check({tag, ".reads"},  rd_cnt - rd0, exp_rd);
    check({tag, ".writes"}, wr_cnt - wr0, exp_wr);
  endtask

  initial begin
    mem[32'h0] = 32'h80FF7F01;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.ready",   {31'h0, req_ready}, 32'h1);
    check("rst.resp",    {30'h0, resp_valid, resp_err}, 32'h0);
    check("rst.rdata",   resp_rdata, 32'h0);
    check("rst.strobe",  {28'h0, mem_sign_mask}, 32'h0);
    check("rst.rw",      {30'h0, mem_memread, mem_memwrite}, 32'h0);
    check("rst.addr",    mem_addr, 32'h0);
    check("rst.wdata",   mem_write_data, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    do_case("lb",  1'b0, 32'h003, 32'h0, 3'b000, 2, 32'hFFFFFF80, 1'b0, 1, 0, 4'b1000);
    do_case("lbu", 1'b0, 32'h003, 32'h0, 3'b100, 2, 32'h00000080, 1'b0, 1, 0, 4'b1000);
    do_case("lh",  1'b0, 32'h002, 32'h0, 3'b001, 2, 32'hFFFF80FF, 1'b0, 1, 0, 4'b1100);
    do_case("lhu", 1'b0, 32'h002, 32'h0, 3'b101, 2, 32'h000080FF, 1'b0, 1, 0, 4'b1100);
    do_case("lw",  1'b0, 32'h000, 32'h0, 3'b010, 2, 32'h80FF7F01, 1'b0, 1, 0, 4'b1111);

    mem[32'h0] = 32'h11223344;
    do_case("sb", 1'b1, 32'h001, 32'h000055AA, 3'b000, 3, 32'h0, 1'b0, 1, 1, 4'b0010);
    check("sb.mem", mem[32'h0], 32'h1122AA44);
    mem[32'h0] = 32'h11223344;
    do_case("sh", 1'b1, 32'h002, 32'h1234BEEF, 3'b001, 3, 32'h0, 1'b0, 1, 1, 4'b1100);
    check("sh.mem", mem[32'h0], 32'hBEEF3344);

    do_case("sw", 1'b1, 32'h8000, 32'h000000A5, 3'b010, 1, 32'h0, 1'b0, 0, 1, 4'b1111);
    check("sw.led", mem.exists(32'h2000) ? mem[32'h2000] : 32'hX, 32'h000000A5);
    check("sw.addr", mem_addr, 32'h2000);

    do_case("e_lw",  1'b0, 32'h002, 32'h0, 3'b010, 1, 32'h0, 1'b1, 0, 0, 4'b0000);
    do_case("e_sh",  1'b1, 32'h001, 32'h0, 3'b001, 1, 32'h0, 1'b1, 0, 0, 4'b0000);
    do_case("e_sbu", 1'b1, 32'h000, 32'h0, 3'b100, 1, 32'h0, 1'b1, 0, 0, 4'b0000);
    do_case("e_f3",  1'b0, 32'h000, 32'h0, 3'b011, 1, 32'h0, 1'b1, 0, 0, 4'b0000);

    // Abort a sub-word store in its merge cycle.
    mem[32'h0] = 32'h11223344;
    begin
      int wr0;
      wr0 = wr_cnt;
      @(posedge clk); #1;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h001;
      req_wdata = 32'hAA; req_funct3 = 3'b000;
      @(posedge clk); #1 req_valid = 1'b0;
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("abort.writes", wr_cnt - wr0, 0);
      check("abort.ready", {31'h0, req_ready}, 32'h1);
      check("abort.mem", mem[32'h0], 32'h11223344);
    end
    do_case("post", 1'b0, 32'h000, 32'h0, 3'b010, 2, 32'h11223344, 1'b0, 1, 0, 4'b1111);

    check("overlap", overlap, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
